add_result_accum: RTL and testbench
===================================

// Module: add_result_accum
// PURPOSE
//  Downstream stage of the 8-bit ripple-carry adder: consumes each {cout,sum} result over a valid/ready handshake.
//  Accumulates BURST_LEN results into a wider running total, then presents that total over a valid/ready output.
//  Sits between the adder datapath and any consumer that needs per-burst sums plus an overflow indication.
// PARAMETERS
//  DATA_W     8   width of incoming sum (cout is one extra bit above it)
//  ACC_W      12  accumulator/total width; must be >= DATA_W+1
//  BURST_LEN  4   results per burst, >= 1; CNT_W = $clog2(BURST_LEN+1)
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       adder result valid
//  in_ready   out  1       stage accepts a result this cycle
//  in_sum     in   DATA_W  adder sum
//  in_cout    in   1       adder carry-out
//  flush      in   1       close current burst early (partial emit)
//  out_valid  out  1       out_total/out_count/out_ovf valid
//  out_ready  in   1       consumer accepts the output
//  out_total  out  ACC_W   burst total
//  out_count  out  CNT_W   number of results in this burst
//  out_ovf    out  1       total overflowed ACC_W during the burst
// BEHAVIOUR
//  - Operand value = {in_cout,in_sum} zero-extended to ACC_W. Accept = in_valid & in_ready.
//  - Reset (rst=1 at clock edge): state ACCUM, acc=0, cnt=0, ovf=0, out_valid=0; in_ready=0 while rst is high.
//    Reset mid-burst or mid-EMIT discards all data; no output is produced for it.
//  - FSM states are ACCUM and EMIT.
//    ACCUM: in_ready=1, out_valid=0. On accept, acc<=acc+value and cnt<=cnt+1.
//    Go to EMIT when cnt+1==BURST_LEN on an accept.
//    Also go to EMIT on flush when the burst is non-empty after this cycle (cnt>0, or an accept in the same cycle).
//    A flush together with an accept includes that sample. A flush with cnt==0 and no accept is ignored.
//    EMIT: in_ready=0, out_valid=1. out_total=acc, out_count=cnt and out_ovf=ovf stay stable until out_ready.
//    On out_ready: acc, cnt and ovf clear to 0, and the FSM returns to ACCUM. flush is ignored in EMIT.
//  - Latency: if the final accept is at edge N, out_valid=1 in the cycle after edge N.
//    The next burst's first accept is possible the cycle after the out handshake; minimum period is BURST_LEN+1 cycles.
//  - Arithmetic: ACC_W+1 bit sum of acc and value. A carry out of ACC_W sets sticky ovf, which persists until the emit handshake.
//  - out_total is registered; out_valid depends only on state (no combinational in->out path).
// CONFIGURATION
//  ADD_RESULT_ACCUM_SAT_EN defined: on overflow, acc clamps to all-ones and stays saturated for the rest of the burst; ovf is set.
//  Not defined: acc wraps modulo 2^ACC_W; ovf is still set.
// STRUCTURE
//  Package add_result_accum_pkg holds:
//   - the state enum (ACCUM, EMIT)
//   - DATA_W/ACC_W/BURST_LEN defaults
//   - a CNT_W function ($clog2(BURST_LEN+1))
//  Sub-module acc_ripple_add holds the ACC_W-bit ripple-carry adder with carry-out, built as a generate chain of 1-bit full-add cells.
//  The FSM, counter, ovf/sat logic and output registers live in the top level.
// TESTING
//  Defaults throughout; backpressure is applied with out_ready=0 unless a scenario states otherwise.
//  1 Basic: four accepts, sums 0x10,0x20,0x30,0x40 with cout=0 -> out_valid the cycle after the 4th accept, out_total=0x0A0, out_count=4, out_ovf=0.
//  2 Carry: four accepts of sum=0xFF, cout=1 -> out_total=0x7FC, out_count=4, out_ovf=0.
//  3 Overflow: ACC_W=10, four accepts of 0x1FF -> out_ovf=1.
//    Without ADD_RESULT_ACCUM_SAT_EN: out_total=0x3FC. With it: out_total=0x3FF.
//  4 Flush:
//    - 0x05, then 0x07 with flush high in the same cycle -> out_total=0x00C, out_count=2.
//    - flush with an empty burst -> no out_valid.
//  5 Backpressure: out_ready=0 for 3 cycles in EMIT -> in_ready=0 and outputs stable.
//    Then out_ready=1 -> handshake, and the next burst starts at 0.
//  6 Reset mid-burst: rst=1 after 2 accepts -> next cycle out_valid=0, cnt=0.
//    A following full burst of 1s gives out_total=0x004.

Source files
------------

// File: rtl/add_result_accum_pkg.sv
// Shared types and defaults for the adder-result burst accumulator.
// Optional saturation is selected with ADD_RESULT_ACCUM_SAT_EN.
package add_result_accum_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ACC_W_DEF     = 12;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_e;

  // Counter must hold values 0..BURST_LEN inclusive.
  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/acc_ripple_add.sv
// W-bit ripple-carry adder with carry-out, one full-add cell per bit.
module acc_ripple_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[W];

endmodule

// File: rtl/add_result_accum.sv
// Accumulates BURST_LEN adder results (or a flushed partial burst) and emits the total.
// Define ADD_RESULT_ACCUM_SAT_EN to saturate the total on overflow instead of wrapping.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid never depends on ready, and payload stays stable while valid is held.
module add_result_accum
  import add_result_accum_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int ACC_W     = ACC_W_DEF,
  parameter  int BURST_LEN = BURST_LEN_DEF,
  localparam int CNT_W     = cnt_w(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output state_e            dbg_state
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   value;
  logic [ACC_W-1:0]   sum_w;
  logic               carry_w;
  logic [ACC_W-1:0]   acc_next;
  logic               accept;

  assign value    = ACC_W'({in_cout, in_sum});
  assign in_ready = (state_q == ST_ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  acc_ripple_add #(.W(ACC_W)) u_add (
    .a_i    (acc_q),
    .b_i    (value),
    .sum_o  (sum_w),
    .cout_o (carry_w)
  );

`ifdef ADD_RESULT_ACCUM_SAT_EN
  // Once saturated, the total stays pinned at all-ones until the burst is emitted.
  assign acc_next = (carry_w || ovf_q) ? '1 : sum_w;
`else
  assign acc_next = sum_w;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | carry_w;
        end
        // A flush only closes a burst that holds at least one sample after this edge.
        if ((accept && (cnt_q == CNT_W'(BURST_LEN - 1))) ||
            (flush && (accept || (cnt_q != '0)))) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_EMIT);
  assign out_total = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_add_result_accum.sv
// Directed and random checks of add_result_accum against a queue-based burst model.
module tb_add_result_accum;
  import add_result_accum_pkg::*;

  localparam int BURST = 4;
`ifdef ADD_RESULT_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_sum;
  logic        in_cout;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_total;
  logic [2:0]  out_count;
  state_e      dbg_state;

  logic        in_ready10, out_valid10, out_ovf10;
  logic [9:0]  out_total10;
  logic [2:0]  out_count10;
  state_e      dbg_state10;

  always #5 clk = ~clk;

  add_result_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
    .out_count(out_count), .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  add_result_accum #(.ACC_W(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10),
    .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
    .out_valid(out_valid10), .out_ready(out_ready), .out_total(out_total10),
    .out_count(out_count10), .out_ovf(out_ovf10), .dbg_state(dbg_state10)
  );

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          passes = 0;
  logic [8:0]  burst_q[$];      // operands of the open burst
  logic [11:0] exp_q[$];        // expected total of the burst being presented
  bit          m_emit = 1'b0;
  logic [11:0] e_tot12;
  logic [9:0]  e_tot10;
  logic [2:0]  e_cnt;
  bit          e_ovf12, e_ovf10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Close the open burst: plain integer sum, then wrap or clamp to each width.
  task automatic close_burst();
    int tot = 0;
    foreach (burst_q[i]) tot += int'(burst_q[i]);
    e_cnt   = 3'(burst_q.size());
    e_ovf12 = (tot >= 4096);
    e_ovf10 = (tot >= 1024);
    e_tot12 = (e_ovf12 && SAT) ? 12'hFFF : 12'(tot % 4096);
    e_tot10 = (e_ovf10 && SAT) ? 10'h3FF : 10'(tot % 1024);
    exp_q.delete();
    exp_q.push_back(e_tot12);
    m_emit  = 1'b1;
  endtask

  // ---------------- driver: one clock cycle per call ----------------
  task automatic drive(input bit v, input logic [7:0] s, input bit c, input bit f,
                       input bit ordy, input bit r);
    in_valid = v; in_sum = s; in_cout = c; flush = f; out_ready = ordy; rst = r;
    #1;
    check("in_ready_pre", in_ready, !m_emit && !r);
    if (r) begin
      burst_q.delete(); exp_q.delete(); m_emit = 1'b0;
    end else if (!m_emit) begin
      if (v) burst_q.push_back({c, s});
      if ((v && burst_q.size() == BURST) || (f && burst_q.size() > 0)) close_burst();
    end else if (ordy) begin
      m_emit = 1'b0; burst_q.delete(); exp_q.delete();
    end
    @(posedge clk); #1;
    check("out_valid", out_valid, m_emit);
    check("out_valid10", out_valid10, m_emit);
    check("state", dbg_state, m_emit ? ST_EMIT : ST_ACCUM);
    if (m_emit) begin
      check("out_total", out_total, exp_q[0]);
      check("out_count", out_count, e_cnt);
      check("out_ovf", out_ovf, e_ovf12);
      check("out_total10", out_total10, e_tot10);
      check("out_count10", out_count10, e_cnt);
      check("out_ovf10", out_ovf10, e_ovf10);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 8'h00, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Reset state
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_count", out_count, 3'd0);
    check("rst_total", out_total, 12'h000);
    idle(1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Basic burst, then 3 cycles of backpressure, then handshake
    drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    check("basic_valid", out_valid, 1'b1);
    check("basic_total", out_total, 12'h0A0);
    check("basic_count", out_count, 3'd4);
    check("basic_ovf", out_ovf, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
      check("bp_total_stable", out_total, 12'h0A0);
      check("bp_in_ready", in_ready, 1'b0);
    end
    idle(1'b1);
    check("bp_released", out_valid, 1'b0);
    check("bp_cleared", out_total, 12'h000);

    // Carry results; the 10-bit instance overflows on the same stimulus
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("carry_total", out_total, 12'h7FC);
    check("carry_count", out_count, 3'd4);
    check("carry_ovf", out_ovf, 1'b0);
    check("ovf10_flag", out_ovf10, 1'b1);
    check("ovf10_total", out_total10, SAT ? 10'h3FF : 10'h3FC);
    idle(1'b1);

    // Flush with a same-cycle accept, then flush on an empty burst
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flush_total", out_total, 12'h00C);
    check("flush_count", out_count, 3'd2);
    idle(1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flush_empty", out_valid, 1'b0);
    idle(1'b0);

    // Reset mid-burst discards it
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_count", out_count, 3'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_total", out_total, 12'h004);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
